reg_writeback: RTL
==================

// Module: reg_writeback
// PURPOSE
//  Write-side sequencer for the 16x8 register file. Accepts results from execute/load units
//  over a valid/ready handshake, buffers them in a small FIFO and drives at most one
//  register-file write per cycle (wr_en, wr_addr, dat_in, flag).
//  Exports a pending-write mask so the decoder can stall on a read of a register
//  that still has a write in flight.
// PARAMETERS
//  PW     4  register address width (2**PW registers)
//  DEPTH  4  FIFO entries; power of two, >=2
// PORTS
//  clk         in   1         clock, all state on posedge
//  reset       in   1         async active-high reset
//  start       in   1         sync flush: new program starting
//  res_valid   in   1         producer has a result
//  res_ready   out  1         FIFO can accept this cycle
//  res_addr    in   PW        destination register
//  res_data    in   8         result value
//  res_flag    in   1         status flag accompanying result
//  hold        in   1         stall drain (reg file busy / pipeline freeze)
//  wr_en       out  1         reg-file write enable (registered)
//  wr_addr     out  PW        reg-file write address (registered)
//  dat_in      out  8         reg-file write data (registered)
//  flag        out  1         flag to status register (registered)
//  pend_mask   out  2**PW     bit i = write to Ri queued or in output stage
//  occupancy   out  $clog2(DEPTH)+1  FIFO entry count
// BEHAVIOUR
//  - Reset (async): FIFO empty, rd/wr ptr 0, occupancy 0, wr_en 0, wr_addr 0, dat_in 0,
//    flag 0, pend_mask 0, res_ready 1 after release.
//  - res_ready = (occupancy != DEPTH) && !start; combinational. Push on res_valid&&res_ready.
//  - Drain: each edge with !hold && occupancy!=0, pop head into output regs, wr_en<=1.
//    Otherwise wr_en<=0; wr_addr/dat_in/flag hold their last values.
//  - wr_en is a single-cycle pulse per entry; back-to-back entries give consecutive pulses.
//  - Latency: push at edge N -> pop at edge N+1 -> reg file commits at edge N+2.
//  - Full with simultaneous pop: res_ready stays 0 (no push-through when full).
//  - Push and pop same edge: occupancy unchanged; entries stay in order.
//  - Pointers wrap modulo DEPTH. Order strictly FIFO: same-address writes land in order.
//  - pend_mask: OR of one-hot(res_addr) over valid FIFO entries, plus one-hot(wr_addr)
//    while wr_en=1. Combinational from state. Does not include the result presented this cycle.
//  - hold: freezes pop only; pushes continue until full.
//  - start (sync, priority over all): ptrs/occupancy->0, wr_en<=0, pushes that cycle are
//    dropped, pend_mask->0 next cycle. The reg file clears R3 on start; the flush keeps stale
//    flags from overwriting it.
//  - Reset asserted mid-stream: immediate clear, in-flight entries lost, no wr_en glitch.
// CONFIGURATION
//  WB_BYPASS_EN defined: when FIFO is empty and (!hold), a pushed result loads output regs
//    directly at the push edge (wr_en<=1, commit one edge earlier); FIFO is not written.
//    pend_mask behaviour unchanged.
//  WB_BYPASS_EN undefined: every result passes through the FIFO (2-edge latency above).
// TESTING
//  1 reset mid-burst, 3 entries queued -> wr_en=0, occupancy=0, pend_mask=0 immediately.
//  2 push R5=0x3C flag=1 at edge 0 -> wr_en=1, wr_addr=5, dat_in=0x3C, flag=1 in cycle after
//    edge 1 (bypass: after edge 0); pend_mask[5]=1 until the wr_en cycle ends.
//  3 hold=1, push 5 results -> 4 accepted, res_ready=0 on the 5th, occupancy=4;
//    release hold -> 4 consecutive wr_en pulses in push order.
//  4 full FIFO, push+pop same edge -> push refused, occupancy 4->3, next cycle accepted.
//  5 push R2=0x11 then R2=0x22 -> writes in order, last dat_in=0x22; pend_mask[2] clears
//    only after the second write.
//  6 start with 3 entries queued and res_valid=1 -> no further wr_en, occupancy=0,
//    pushed result dropped.

Source files
------------

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file write sequencer: result FIFO, registered write port, pending mask
// Optional WB_BYPASS_EN: a result pushed into an empty, unheld FIFO loads the write port directly.
module reg_writeback #(
  parameter int PW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [PW-1:0]              res_addr,
  input  logic [7:0]                 res_data,
  input  logic                       res_flag,
  input  logic                       hold,
  output logic                       wr_en,
  output logic [PW-1:0]              wr_addr,
  output logic [7:0]                 dat_in,
  output logic                       flag,
  output logic [(2**PW)-1:0]         pend_mask,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]      r_addr_q [DEPTH];
  logic [7:0]         r_data_q [DEPTH];
  logic               r_flag_q [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_occ;
  logic               r_wr_en;
  logic [PW-1:0]      r_wr_addr;
  logic [7:0]         r_dat;
  logic               r_flag;

  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_bypass;
  logic               w_fifo_push;
  logic [(2**PW)-1:0] w_pend;

  assign w_ready     = (r_occ != CW'(DEPTH)) && !start;
  assign w_push      = res_valid && w_ready;
  assign w_pop       = !hold && (r_occ != '0);
`ifdef WB_BYPASS_EN
  assign w_bypass    = w_push && (r_occ == '0) && !hold;
`else
  assign w_bypass    = 1'b0;
`endif
  assign w_fifo_push = w_push && !w_bypass;

  always_ff @(posedge clk) begin
    if (w_fifo_push) begin
      r_addr_q[r_wr_ptr] <= res_addr;
      r_data_q[r_wr_ptr] <= res_data;
      r_flag_q[r_wr_ptr] <= res_flag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_occ     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_dat     <= '0;
      r_flag    <= 1'b0;
    end else if (start) begin
      // Flush drops queued stale results so they cannot overwrite the freshly cleared registers.
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_occ     <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      if (w_fifo_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ <= r_occ + CW'(w_fifo_push) - CW'(w_pop);
      if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr_q[r_rd_ptr];
        r_dat     <= r_data_q[r_rd_ptr];
        r_flag    <= r_flag_q[r_rd_ptr];
      end else if (w_bypass) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= res_addr;
        r_dat     <= res_data;
        r_flag    <= res_flag;
      end else begin
        r_wr_en   <= 1'b0;
      end
    end
  end

  // Slots from the read pointer up to occupancy are live; the output stage counts while wr_en is high.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_occ) w_pend[r_addr_q[r_rd_ptr + AW'(i)]] = 1'b1;
    end
    if (r_wr_en) w_pend[r_wr_addr] = 1'b1;
  end

  assign res_ready = w_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign dat_in    = r_dat;
  assign flag      = r_flag;
  assign pend_mask = w_pend;
  assign occupancy = r_occ;

endmodule
